// File: rtl/reg_file_mp_pkg.sv
// Shared register-file definitions: architectural register indices, reset
// values for the global and stack pointers, and the register address type.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;
  localparam int REG_FP   = 30;
  localparam int REG_RA   = 31;

  localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;
  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;

  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports,
// issue/flush control and the scoreboard status returned to the hazard unit.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2
);
  logic [NUM_RD*ADDR_W-1:0] Rd_addr;
  logic [NUM_RD*DATA_W-1:0] Rd_data;
  logic [NUM_RD-1:0]        Rd_busy;
  logic [NUM_WR-1:0]        Wr_en;
  logic [NUM_WR*ADDR_W-1:0] Wr_addr;
  logic [NUM_WR*DATA_W-1:0] Wr_data;
  logic                     Issue_en;
  logic [ADDR_W-1:0]        Issue_addr;
  logic                     Flush;
  logic                     Wr_conflict;
  logic [NUM_REGS-1:0]      Busy_vec;

  modport master (
    output Rd_addr, Wr_en, Wr_addr, Wr_data, Issue_en, Issue_addr, Flush,
    input  Rd_data, Rd_busy, Wr_conflict, Busy_vec
  );

  modport slave (
    input  Rd_addr, Wr_en, Wr_addr, Wr_data, Issue_en, Issue_addr, Flush,
    output Rd_data, Rd_busy, Wr_conflict, Busy_vec
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared
// by writeback, wiped by flush. Register 0 is never marked busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_WR   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  input  logic [NUM_WR-1:0]        wr_ok,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_en && issue_addr != ADDR_W'(REG_ZERO))
      set_mask[issue_addr] = 1'b1;
    for (int w = 0; w < NUM_WR; w++)
      if (wr_ok[w])
        clr_mask[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
  end

  // A same-cycle issue beats the writeback clear: the new producer supersedes the old.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else if (flush)
      busy <= '0;
    else
      busy <= set_mask | (busy & ~clr_mask);
  end

  assign busy_vec = busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-through bypass, higher-port-wins write
// arbitration, a registered same-address write conflict flag and a scoreboard.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int               DATA_W   = 32,
  parameter int               NUM_REGS = 32,
  parameter int               ADDR_W   = $clog2(NUM_REGS),
  parameter int               NUM_RD   = 2,
  parameter int               NUM_WR   = 2,
  parameter int               BYPASS   = 1,
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GP_INIT_DEF),
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
  input  logic         CLK,
  input  logic         RESET_N,
  reg_file_mp_if.slave bus
);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [ADDR_W-1:0]        wa   [NUM_WR];
  logic [DATA_W-1:0]        wd   [NUM_WR];
  logic [NUM_WR-1:0]        wr_ok;
  logic                     conflict;
  logic                     conflict_q;
  logic [NUM_REGS-1:0]      busy_vec;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  function automatic logic [DATA_W-1:0] reset_val(input int r);
    if (r == REG_GP) return GP_INIT;
    if (r == REG_SP) return SP_INIT;
    return '0;
  endfunction

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w]    = bus.Wr_addr[w*ADDR_W +: ADDR_W];
      wd[w]    = bus.Wr_data[w*DATA_W +: DATA_W];
      wr_ok[w] = bus.Wr_en[w] && (wa[w] != ADDR_W'(REG_ZERO));
    end
  end

  // Later ports are applied last, so the highest-index port wins a collision.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= reset_val(r);
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_ok[w])
          regs[wa[w]] <= wd[w];
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++)
      for (int j = i + 1; j < NUM_WR; j++)
        if (wr_ok[i] && wr_ok[j] && (wa[i] == wa[j]))
          conflict = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      conflict_q <= 1'b0;
    else
      conflict_q <= conflict;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .issue_en   (bus.Issue_en),
    .issue_addr (bus.Issue_addr),
    .flush      (bus.Flush),
    .wr_ok      (wr_ok),
    .wr_addr    (bus.Wr_addr),
    .busy_vec   (busy_vec)
  );

  // A bypassed read also hides the busy bit: the value is already on the bus.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] val;
      logic              hit;
      ra  = bus.Rd_addr[p*ADDR_W +: ADDR_W];
      val = regs[ra];
      hit = 1'b0;
      if (BYPASS != 0)
        for (int w = 0; w < NUM_WR; w++)
          if (wr_ok[w] && (wa[w] == ra)) begin
            hit = 1'b1;
            val = wd[w];
          end
      if (ra == ADDR_W'(REG_ZERO))
        val = '0;
      rd_data[p*DATA_W +: DATA_W] = val;
      rd_busy[p] = busy_vec[ra] && !hit && (ra != ADDR_W'(REG_ZERO));
    end
  end

  assign bus.Rd_data     = rd_data;
  assign bus.Rd_busy     = rd_busy;
  assign bus.Wr_conflict = conflict_q;
  assign bus.Busy_vec    = busy_vec;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized bench for reg_file_mp: one bypassing and one
// non-bypassing instance share stimulus and are checked against an array model.
module tb_reg_file_mp;
  import regfile_pkg::*;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic              flush;

  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus1 ();
  reg_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus0 ();

  assign bus1.Rd_addr = rd_addr;  assign bus0.Rd_addr = rd_addr;
  assign bus1.Wr_en   = wr_en;    assign bus0.Wr_en   = wr_en;
  assign bus1.Wr_addr = wr_addr;  assign bus0.Wr_addr = wr_addr;
  assign bus1.Wr_data = wr_data;  assign bus0.Wr_data = wr_data;
  assign bus1.Issue_en = issue_en;     assign bus0.Issue_en = issue_en;
  assign bus1.Issue_addr = issue_addr; assign bus0.Issue_addr = issue_addr;
  assign bus1.Flush = flush;      assign bus0.Flush = flush;

  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1))
    dut1 (.CLK(clk), .RESET_N(rst_n), .bus(bus1));
  reg_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0))
    dut0 (.CLK(clk), .RESET_N(rst_n), .bus(bus0));

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic          m_conf;

  function automatic int wa(input int w);
    return int'(wr_addr[w*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] wd(input int w);
    return wr_data[w*DW +: DW];
  endfunction

  function automatic bit same_cycle_write(input int a);
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wa(w) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
    logic [DW-1:0] v;
    if (a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wa(w) == a) v = wd(w);
    return v;
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && same_cycle_write(a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_regs[28] = 32'h1000_8000;
    m_regs[29] = 32'h7FFF_EFFC;
    m_busy = '0;
    m_conf = 1'b0;
  endtask

  task automatic model_edge();
    bit written [NR];
    for (int r = 0; r < NR; r++) written[r] = 1'b0;
    m_conf = wr_en[0] && wr_en[1] && (wa(0) == wa(1)) && (wa(0) != 0);
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wa(w) != 0) begin
        m_regs[wa(w)] = wd(w);
        written[wa(w)] = 1'b1;
      end
    for (int r = 1; r < NR; r++) begin
      if (flush) m_busy[r] = 1'b0;
      else if (issue_en && int'(issue_addr) == r) m_busy[r] = 1'b1;
      else if (written[r]) m_busy[r] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int p = 0; p < NRD; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      chk($sformatf("%s rd%0d data byp", tag, p), 64'(bus1.Rd_data[p*DW +: DW]), 64'(exp_data(a, 1'b1)));
      chk($sformatf("%s rd%0d data nobyp", tag, p), 64'(bus0.Rd_data[p*DW +: DW]), 64'(exp_data(a, 1'b0)));
      chk($sformatf("%s rd%0d busy byp", tag, p), 64'(bus1.Rd_busy[p]), 64'(exp_busy(a, 1'b1)));
      chk($sformatf("%s rd%0d busy nobyp", tag, p), 64'(bus0.Rd_busy[p]), 64'(exp_busy(a, 1'b0)));
    end
    chk({tag, " busy_vec byp"}, 64'(bus1.Busy_vec), 64'(m_busy));
    chk({tag, " busy_vec nobyp"}, 64'(bus0.Busy_vec), 64'(m_busy));
    chk({tag, " conflict byp"}, 64'(bus1.Wr_conflict), 64'(m_conf));
    chk({tag, " conflict nobyp"}, 64'(bus0.Wr_conflict), 64'(m_conf));
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w] = 1'b1;
    wr_addr[w*AW +: AW] = AW'(a);
    wr_data[w*DW +: DW] = d;
  endtask

  task automatic issue(input int a);
    issue_en = 1'b1;
    issue_addr = AW'(a);
  endtask

  // Inputs change at the falling edge; checks run 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rd_addr = '0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);

    // Reset contents
    set_rd(0, 28); set_rd(1, 29); #1;
    check_all("reset gp/sp");
    chk("reset reg28", 64'(bus1.Rd_data[0 +: DW]), 64'h1000_8000);
    chk("reset reg29", 64'(bus1.Rd_data[DW +: DW]), 64'h7FFF_EFFC);
    set_rd(0, 5); #1;
    chk("reset reg5", 64'(bus1.Rd_data[0 +: DW]), 64'h0);
    check_all("reset reg5");
    rst_n = 1'b1;
    tick();

    // Write and read the same register in one cycle
    wr(0, 8, 32'hDEAD_BEEF); set_rd(1, 8); #1;
    chk("same-cycle bypass", 64'(bus1.Rd_data[DW +: DW]), 64'hDEAD_BEEF);
    chk("same-cycle no bypass", 64'(bus0.Rd_data[DW +: DW]), 64'h0);
    check_all("wr8");
    tick(); idle(); #1;
    chk("next-cycle byp", 64'(bus1.Rd_data[DW +: DW]), 64'hDEAD_BEEF);
    chk("next-cycle nobyp", 64'(bus0.Rd_data[DW +: DW]), 64'hDEAD_BEEF);

    // Register 0 ignores writes and issues
    wr(0, 0, 32'h1234); issue(0); set_rd(0, 0); #1;
    check_all("reg0 wr");
    tick(); idle(); #1;
    chk("reg0 read", 64'(bus1.Rd_data[0 +: DW]), 64'h0);
    chk("reg0 busy", 64'(bus1.Busy_vec[0]), 64'h0);
    check_all("reg0 after");

    // Dual-write collision on reg 9
    wr(0, 9, 32'hAAAA); wr(1, 9, 32'hBBBB); set_rd(0, 9); #1;
    check_all("conflict wr");
    tick(); idle(); #1;
    chk("conflict winner", 64'(bus0.Rd_data[0 +: DW]), 64'hBBBB);
    chk("conflict pulse", 64'(bus1.Wr_conflict), 64'h1);
    check_all("conflict +1");
    tick(); #1;
    chk("conflict drop", 64'(bus1.Wr_conflict), 64'h0);

    // Scoreboard on reg 12
    set_rd(0, 12); set_rd(1, 13); issue(12); #1;
    check_all("issue12");
    tick(); idle(); #1;
    chk("issue12 busy", 64'(bus1.Rd_busy[0]), 64'h1);
    issue(12); wr(0, 12, 32'h0C0C); #1;
    check_all("issue+wr12");
    tick(); idle(); #1;
    chk("issue+wr keeps busy", 64'(bus1.Busy_vec[12]), 64'h1);
    wr(1, 12, 32'h1212); #1;
    chk("wb clears byp now", 64'(bus1.Rd_busy[0]), 64'h0);
    chk("wb nobyp still busy", 64'(bus0.Rd_busy[0]), 64'h1);
    check_all("wb12");
    tick(); idle();
    issue(12); tick(); idle();
    issue(13); tick(); idle(); #1;
    check_all("busy 12/13");
    flush = 1'b1; tick(); idle(); #1;
    chk("flush busy_vec", 64'(bus1.Busy_vec), 64'h0);
    chk("flush keeps data", 64'(bus0.Rd_data[0 +: DW]), 64'h1212);
    check_all("flush");

    // Asynchronous reset while a write is pending
    wr(0, 3, 32'h77); tick(); idle();
    set_rd(0, 3); set_rd(1, 3); #1;
    chk("reg3 before reset", 64'(bus0.Rd_data[0 +: DW]), 64'h77);
    wr(0, 3, 32'h55); #2;
    rst_n = 1'b0; model_reset(); #1;
    chk("reg3 in reset", 64'(bus0.Rd_data[0 +: DW]), 64'h0);
    check_all("async reset");
    tick(); idle(); #1;
    check_all("held reset");
    rst_n = 1'b1;
    tick(); #1;
    chk("reg3 after release", 64'(bus1.Rd_data[0 +: DW]), 64'h0);
    check_all("after release");

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 600; cyc++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? NR - 1 : 15;
      idle();
      for (int p = 0; p < NRD; p++) set_rd(p, int'($urandom_range(0, hi)));
      for (int w = 0; w < NWR; w++)
        if ($urandom_range(0, 1) == 1) wr(w, int'($urandom_range(0, hi)), $urandom);
      if ($urandom_range(0, 1) == 1) issue(int'($urandom_range(0, hi)));
      flush = ($urandom_range(0, 15) == 0);
      #1;
      check_all($sformatf("rand%0d", cyc));
      if (cyc == 300) begin
        #2; rst_n = 1'b0; model_reset(); #1;
        check_all("rand reset");
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    idle(); #1;
    check_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
